// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, the RAM port and the read-return signals
// shared between ram_port_arbiter (slave side) and whoever drives it (master side).
interface ram_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    logic                     i_req0_valid;
    logic                     o_req0_ready;
    logic [ADDRESS_WIDTH-1:0] i_req0_addr;
    logic                     i_req0_we;
    logic [DATA_WIDTH-1:0]    i_req0_din;

    logic                     i_req1_valid;
    logic                     o_req1_ready;
    logic [ADDRESS_WIDTH-1:0] i_req1_addr;
    logic                     i_req1_we;
    logic [DATA_WIDTH-1:0]    i_req1_din;

    logic [ADDRESS_WIDTH-1:0] o_ram_addr;
    logic                     o_ram_en;
    logic                     o_ram_we;
    logic [DATA_WIDTH-1:0]    o_ram_din;
    logic [DATA_WIDTH-1:0]    i_ram_dout;

    logic                     o_rvalid0;
    logic                     o_rvalid1;
    logic [DATA_WIDTH-1:0]    o_rdata;

    modport slave (
        input  i_req0_valid, i_req0_addr, i_req0_we, i_req0_din,
        input  i_req1_valid, i_req1_addr, i_req1_we, i_req1_din,
        input  i_ram_dout,
        output o_req0_ready, o_req1_ready,
        output o_ram_addr, o_ram_en, o_ram_we, o_ram_din,
        output o_rvalid0, o_rvalid1, o_rdata
    );

    modport master (
        output i_req0_valid, i_req0_addr, i_req0_we, i_req0_din,
        output i_req1_valid, i_req1_addr, i_req1_we, i_req1_din,
        output i_ram_dout,
        input  o_req0_ready, o_req1_ready,
        input  o_ram_addr, o_ram_en, o_ram_we, o_ram_din,
        input  o_rvalid0, o_rvalid1, o_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter onto a single RAM port with tagged read returns.
// Optional read-after-write hazard blocking is enabled by defining RAM_ARB_RAW_HAZARD_EN.
module ram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int WRITE_LATENCY = 2,
    parameter int READ_LATENCY  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ram_port_arbiter_if.slave   bus
);

    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
        $error("ram_port_arbiter: latencies must be at least 1");
    end

    logic                     last_r;
    logic                     elig0_s;
    logic                     elig1_s;
    logic                     gnt0_s;
    logic                     gnt1_s;
    logic                     haz0_s;
    logic                     haz1_s;

    logic                     ram_en_r;
    logic                     ram_we_r;
    logic [ADDRESS_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0]    ram_din_r;
    logic                     ram_id_r;

    logic [READ_LATENCY-1:0]  tag_valid_r;
    logic [READ_LATENCY-1:0]  tag_id_r;

`ifdef RAM_ARB_RAW_HAZARD_EN
    // Stage 0 mirrors the write currently on the RAM port; older writes shift up.
    logic [WRITE_LATENCY-1:0]                    wtrk_valid_r;
    logic [WRITE_LATENCY-1:0][ADDRESS_WIDTH-1:0] wtrk_addr_r;

    function automatic logic raw_hit(
        input logic [ADDRESS_WIDTH-1:0]                    addr,
        input logic [WRITE_LATENCY-1:0]                    valid,
        input logic [WRITE_LATENCY-1:0][ADDRESS_WIDTH-1:0] taddr
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WRITE_LATENCY; i++) begin
            if (valid[i] && (taddr[i] == addr)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Reads colliding with an outstanding write stay ineligible.
    always_comb begin
        haz0_s = 1'b0;
        haz1_s = 1'b0;
        if (!bus.i_req0_we) begin
            haz0_s = raw_hit(bus.i_req0_addr, wtrk_valid_r, wtrk_addr_r);
        end else begin
            haz0_s = 1'b0;
        end
        if (!bus.i_req1_we) begin
            haz1_s = raw_hit(bus.i_req1_addr, wtrk_valid_r, wtrk_addr_r);
        end else begin
            haz1_s = 1'b0;
        end
    end

    // Write tracker shift register, loaded alongside the RAM port registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wtrk_valid_r <= '0;
            wtrk_addr_r  <= '0;
        end else begin
            for (int i = WRITE_LATENCY - 1; i > 0; i--) begin
                wtrk_valid_r[i] <= wtrk_valid_r[i-1];
                wtrk_addr_r[i]  <= wtrk_addr_r[i-1];
            end
            wtrk_valid_r[0] <= (gnt0_s && bus.i_req0_we) || (gnt1_s && bus.i_req1_we);
            wtrk_addr_r[0]  <= gnt1_s ? bus.i_req1_addr : bus.i_req0_addr;
        end
    end
`else
    // No address comparison: every valid request is eligible.
    always_comb begin
        haz0_s = 1'b0;
        haz1_s = 1'b0;
    end
`endif

    // Grant selection; last_r holds the index granted most recently.
    always_comb begin
        elig0_s = bus.i_req0_valid && !haz0_s && !i_rst;
        elig1_s = bus.i_req1_valid && !haz1_s && !i_rst;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (elig0_s && elig1_s) begin
            if (last_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign bus.o_req0_ready = gnt0_s;
    assign bus.o_req1_ready = gnt1_s;

    // Round-robin pointer; reset as if requester 1 went last so requester 0 leads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_r <= 1'b1;
        end else if (gnt0_s) begin
            last_r <= 1'b0;
        end else if (gnt1_s) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end

    // RAM port drive registers; address/data hold when idle, enables drop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
            ram_id_r   <= 1'b0;
        end else if (gnt0_s) begin
            ram_en_r   <= 1'b1;
            ram_we_r   <= bus.i_req0_we;
            ram_addr_r <= bus.i_req0_addr;
            ram_din_r  <= bus.i_req0_din;
            ram_id_r   <= 1'b0;
        end else if (gnt1_s) begin
            ram_en_r   <= 1'b1;
            ram_we_r   <= bus.i_req1_we;
            ram_addr_r <= bus.i_req1_addr;
            ram_din_r  <= bus.i_req1_din;
            ram_id_r   <= 1'b1;
        end else begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= ram_addr_r;
            ram_din_r  <= ram_din_r;
            ram_id_r   <= ram_id_r;
        end
    end

    // Read tag pipeline; reset flushes reads already on the RAM port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
            tag_valid_r[0] <= ram_en_r && !ram_we_r;
            tag_id_r[0]    <= ram_id_r;
        end
    end

    assign bus.o_ram_en   = ram_en_r;
    assign bus.o_ram_we   = ram_we_r;
    assign bus.o_ram_addr = ram_addr_r;
    assign bus.o_ram_din  = ram_din_r;

    assign bus.o_rvalid0  = tag_valid_r[READ_LATENCY-1] && !tag_id_r[READ_LATENCY-1];
    assign bus.o_rvalid1  = tag_valid_r[READ_LATENCY-1] &&  tag_id_r[READ_LATENCY-1];
    assign bus.o_rdata    = bus.i_ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a small behavioural RAM behind the port.
// Expectations for the hazard case follow whether RAM_ARB_RAW_HAZARD_EN is defined.
module tb_ram_port_arbiter;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;
    logic [7:0] mem [256];

    ram_port_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

    ram_port_arbiter #(
        .ADDRESS_WIDTH(8),
        .DATA_WIDTH   (8),
        .WRITE_LATENCY(2),
        .READ_LATENCY (1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read data, writes land on the issue edge.
    always @(posedge clk) begin
        if (bus.o_ram_en && bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_din;
        if (bus.o_ram_en && !bus.o_ram_we) bus.i_ram_dout <= mem[bus.o_ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ram_idle(input string tag);
        check_val({tag, "_en"},  {31'd0, bus.o_ram_en},    32'd0);
        check_val({tag, "_we"},  {31'd0, bus.o_ram_we},    32'd0);
        check_val({tag, "_rv0"}, {31'd0, bus.o_rvalid0},   32'd0);
        check_val({tag, "_rv1"}, {31'd0, bus.o_rvalid1},   32'd0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        bus.i_req0_valid = 1'b0; bus.i_req0_we = 1'b0; bus.i_req0_addr = 8'h00; bus.i_req0_din = 8'h00;
        bus.i_req1_valid = 1'b0; bus.i_req1_we = 1'b0; bus.i_req1_addr = 8'h00; bus.i_req1_din = 8'h00;
        tick();
        tick();

        // Reset state: no grant even with both valid, outputs cleared
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        #1;
        check_val("rst_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
        check_val("rst_rdy1", {31'd0, bus.o_req1_ready}, 32'd0);
        check_ram_idle("rst");
        check_val("rst_addr", {24'd0, bus.o_ram_addr}, 32'd0);
        check_val("rst_din",  {24'd0, bus.o_ram_din},  32'd0);
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single write from req0
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b1; bus.i_req0_addr = 8'h10; bus.i_req0_din = 8'hA5;
        #1;
        check_val("wr_rdy0", {31'd0, bus.o_req0_ready}, 32'd1);
        check_val("wr_rdy1", {31'd0, bus.o_req1_ready}, 32'd0);
        tick();
        bus.i_req0_valid = 1'b0;
        #1;
        check_val("wr_en",   {31'd0, bus.o_ram_en},   32'd1);
        check_val("wr_we",   {31'd0, bus.o_ram_we},   32'd1);
        check_val("wr_addr", {24'd0, bus.o_ram_addr}, 32'h10);
        check_val("wr_din",  {24'd0, bus.o_ram_din},  32'hA5);
        tick();
        check_ram_idle("wr_after");
        tick();
        tick();
        tick();

        // req1 reads the written location back
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 8'h10;
        #1;
        check_val("rd_rdy1", {31'd0, bus.o_req1_ready}, 32'd1);
        tick();
        bus.i_req1_valid = 1'b0;
        #1;
        check_val("rd_en",   {31'd0, bus.o_ram_en},   32'd1);
        check_val("rd_we",   {31'd0, bus.o_ram_we},   32'd0);
        check_val("rd_addr", {24'd0, bus.o_ram_addr}, 32'h10);
        check_val("rd_rv1_early", {31'd0, bus.o_rvalid1}, 32'd0);
        tick();
        check_val("rd_rv1",   {31'd0, bus.o_rvalid1}, 32'd1);
        check_val("rd_rv0",   {31'd0, bus.o_rvalid0}, 32'd0);
        check_val("rd_rdata", {24'd0, bus.o_rdata},   32'hA5);
        tick();
        check_val("rd_rv1_late", {31'd0, bus.o_rvalid1}, 32'd0);

        // Idle gap after a req1 grant, then both valid: req0 wins, then alternation
        for (int i = 0; i < 5; i++) tick();
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b0; bus.i_req0_addr = 8'h01;
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 8'h02;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val($sformatf("rr_rdy0_%0d", k), {31'd0, bus.o_req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("rr_rdy1_%0d", k), {31'd0, bus.o_req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_val($sformatf("rr_rv0_%0d", k), {31'd0, bus.o_rvalid0}, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("rr_rv1_%0d", k), {31'd0, bus.o_rvalid1}, (k >= 2 && k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset while a read is on the RAM port: it is discarded
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b0; bus.i_req0_addr = 8'h30;
        #1;
        check_val("rrst_rdy0", {31'd0, bus.o_req0_ready}, 32'd1);
        tick();
        bus.i_req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rrst_en_issue", {31'd0, bus.o_ram_en}, 32'd1);
        tick();
        check_ram_idle("rrst_t1");
        check_val("rrst_addr", {24'd0, bus.o_ram_addr}, 32'd0);
        check_val("rrst_din",  {24'd0, bus.o_ram_din},  32'd0);
        bus.i_req0_valid = 1'b1; bus.i_req0_addr = 8'h03;
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 8'h04;
        #1;
        check_val("rrst_rdy0", {31'd0, bus.o_req0_ready}, 32'd0);
        check_val("rrst_rdy1", {31'd0, bus.o_req1_ready}, 32'd0);
        tick();
        check_ram_idle("rrst_t2");
        rst = 1'b0;

        // Both held valid from reset release: 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val($sformatf("rel_rdy0_%0d", k), {31'd0, bus.o_req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("rel_rdy1_%0d", k), {31'd0, bus.o_req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Write then read of the same address on the following cycle
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b1; bus.i_req0_addr = 8'h20; bus.i_req0_din = 8'h5A;
        #1;
        check_val("haz_wr_rdy0", {31'd0, bus.o_req0_ready}, 32'd1);
        tick();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 8'h20;
        #1;
`ifdef RAM_ARB_RAW_HAZARD_EN
        check_val("haz_rdy1_t1", {31'd0, bus.o_req1_ready}, 32'd0);
        tick();
        check_val("haz_rdy1_t2", {31'd0, bus.o_req1_ready}, 32'd0);
        tick();
        check_val("haz_rdy1_t3", {31'd0, bus.o_req1_ready}, 32'd1);
`else
        check_val("haz_rdy1_t1", {31'd0, bus.o_req1_ready}, 32'd1);
`endif
        tick();
        bus.i_req1_valid = 1'b0;
        #1;
        check_val("haz_rd_en",   {31'd0, bus.o_ram_en},   32'd1);
        check_val("haz_rd_we",   {31'd0, bus.o_ram_we},   32'd0);
        check_val("haz_rd_addr", {24'd0, bus.o_ram_addr}, 32'h20);
        tick();
        check_val("haz_rv1",   {31'd0, bus.o_rvalid1}, 32'd1);
        check_val("haz_rdata", {24'd0, bus.o_rdata},   32'h5A);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
